// File: rtl/money_bcd_converter.sv
// Sequential double-dabble converter: snapshots five money values once per frame and publishes their BCD digits as one set.
// Optional build macro MONEY_BCD_BLANK_EN publishes leading zeros as 4'hF (rendered as a space by the overlay).
module money_bcd_converter #(
    parameter int VAL_W      = 11,
    parameter int NUM_DIGITS = 4
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic                                 frame_start,
    input  logic [1:0][VAL_W-1:0]                player_stacks,
    input  logic [1:0][VAL_W-1:0]                player_pots,
    input  logic [VAL_W-1:0]                     pot_size,
    output logic [1:0][NUM_DIGITS-1:0][3:0]      stack_bcd,
    output logic [1:0][NUM_DIGITS-1:0][3:0]      pot_bcd,
    output logic [NUM_DIGITS-1:0][3:0]           total_bcd,
    output logic                                 busy,
    output logic                                 done,
    output logic                                 digits_valid
);

    localparam int          NUM_CH    = 5;
    localparam int          BCD_W     = NUM_DIGITS * 4;
    localparam int          SR_W      = BCD_W + VAL_W;
    localparam int          CNT_W     = $clog2(VAL_W + 1);
    localparam logic [63:0] SAT_LIMIT = 64'(10 ** NUM_DIGITS);

    typedef enum logic [1:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_STORE
    } state_t;

    state_t                             r_state;
    state_t                             w_next;
    logic [2:0]                         r_ch;
    logic [CNT_W-1:0]                   r_iter;
    logic [SR_W-1:0]                    r_sr;
    logic                               r_sat;
    logic [VAL_W-1:0]                   r_shadow [NUM_CH];
    logic [NUM_DIGITS-1:0][3:0]         r_stage  [NUM_CH-1];
    logic [1:0][NUM_DIGITS-1:0][3:0]    r_stack_bcd;
    logic [1:0][NUM_DIGITS-1:0][3:0]    r_pot_bcd;
    logic [NUM_DIGITS-1:0][3:0]         r_total_bcd;
    logic                               r_done;
    logic                               r_valid;

    logic [VAL_W-1:0]                   w_cur_val;
    logic                               w_last_ch;
    logic                               w_last_iter;
    logic [SR_W-1:0]                    w_sr_adj;
    logic [SR_W-1:0]                    w_sr_next;
    logic [NUM_DIGITS-1:0][3:0]         w_digits_raw;
    logic [NUM_DIGITS-1:0][3:0]         w_digits;

    assign w_cur_val   = r_shadow[r_ch];
    assign w_last_ch   = (r_ch == 3'(NUM_CH - 1));
    assign w_last_iter = (r_iter == CNT_W'(VAL_W - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (frame_start) w_next = S_LOAD;
            S_LOAD:  w_next = S_SHIFT;
            S_SHIFT: if (w_last_iter) w_next = S_STORE;
            S_STORE: w_next = w_last_ch ? S_IDLE : S_LOAD;
            default: w_next = S_IDLE;
        endcase
    end

    // Double-dabble step: correct every BCD nibble >= 5 by +3, then shift the whole register left.
    always_comb begin
        w_sr_adj = r_sr;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (r_sr[VAL_W + 4*k +: 4] >= 4'd5) begin
                w_sr_adj[VAL_W + 4*k +: 4] = r_sr[VAL_W + 4*k +: 4] + 4'd3;
            end
        end
    end

    assign w_sr_next = w_sr_adj << 1;

    // Digit index 0 is the most significant digit, so the nibble order is reversed here.
    always_comb begin
        w_digits_raw = '0;
        for (int d = 0; d < NUM_DIGITS; d++) begin
            w_digits_raw[d] = r_sat ? 4'd9 : r_sr[VAL_W + 4*(NUM_DIGITS-1-d) +: 4];
        end
    end

`ifdef MONEY_BCD_BLANK_EN
    logic w_leading;

    always_comb begin
        w_digits  = w_digits_raw;
        w_leading = 1'b1;
        for (int d = 0; d < NUM_DIGITS - 1; d++) begin
            if (w_leading && (w_digits_raw[d] == 4'd0)) begin
                w_digits[d] = 4'hF;
            end else begin
                w_leading = 1'b0;
            end
        end
    end
`else
    always_comb begin
        w_digits = w_digits_raw;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ch        <= '0;
            r_iter      <= '0;
            r_sr        <= '0;
            r_sat       <= 1'b0;
            r_stack_bcd <= '0;
            r_pot_bcd   <= '0;
            r_total_bcd <= '0;
            r_done      <= 1'b0;
            r_valid     <= 1'b0;
            for (int c = 0; c < NUM_CH; c++) begin
                r_shadow[c] <= '0;
            end
            for (int c = 0; c < NUM_CH - 1; c++) begin
                r_stage[c] <= '0;
            end
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (frame_start) begin
                        r_shadow[0] <= player_stacks[0];
                        r_shadow[1] <= player_stacks[1];
                        r_shadow[2] <= player_pots[0];
                        r_shadow[3] <= player_pots[1];
                        r_shadow[4] <= pot_size;
                        r_ch        <= '0;
                    end
                end
                S_LOAD: begin
                    r_sr   <= {{BCD_W{1'b0}}, w_cur_val};
                    r_iter <= '0;
                    r_sat  <= (64'(w_cur_val) >= SAT_LIMIT);
                end
                S_SHIFT: begin
                    r_sr   <= w_sr_next;
                    r_iter <= r_iter + CNT_W'(1);
                end
                S_STORE: begin
                    // The last channel bypasses staging and goes straight to the outputs with the rest.
                    if (w_last_ch) begin
                        r_stack_bcd[0] <= r_stage[0];
                        r_stack_bcd[1] <= r_stage[1];
                        r_pot_bcd[0]   <= r_stage[2];
                        r_pot_bcd[1]   <= r_stage[3];
                        r_total_bcd    <= w_digits;
                        r_done         <= 1'b1;
                        r_valid        <= 1'b1;
                    end else begin
                        r_stage[r_ch[1:0]] <= w_digits;
                        r_ch               <= r_ch + 3'd1;
                    end
                end
                default: begin
                    r_ch <= '0;
                end
            endcase
        end
    end

    assign stack_bcd    = r_stack_bcd;
    assign pot_bcd      = r_pot_bcd;
    assign total_bcd    = r_total_bcd;
    assign busy         = (r_state != S_IDLE);
    assign done         = r_done;
    assign digits_valid = r_valid;

endmodule

// File: tb/tb_money_bcd_converter.sv
// Scoreboard bench for money_bcd_converter: directed frames push expected digit sets, a monitor checks each publish and the hold between publishes.
// Honours MONEY_BCD_BLANK_EN by blanking the hand-written expected digits the same way the overlay expects.
module tb_money_bcd_converter;

    typedef struct {
        logic [15:0] s0;
        logic [15:0] s1;
        logic [15:0] p0;
        logic [15:0] p1;
        logic [15:0] t;
        int          doneCyc;
    } expT;

    logic                  clk;
    logic                  reset;
    logic                  frameStart;
    logic [1:0][10:0]      playerStacks;
    logic [1:0][10:0]      playerPots;
    logic [10:0]           potSize;
    logic [1:0][3:0][3:0]  stackBcd;
    logic [1:0][3:0][3:0]  potBcd;
    logic [3:0][3:0]       totalBcd;
    logic                  busy;
    logic                  done;
    logic                  digitsValid;

    expT         sbq[$];
    expT         cur;
    logic [79:0] held;
    logic        expValid;
    int          cyc;
    int          totalCnt;
    int          badCnt;

    money_bcd_converter #(.VAL_W(11), .NUM_DIGITS(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .frame_start  (frameStart),
        .player_stacks(playerStacks),
        .player_pots  (playerPots),
        .pot_size     (potSize),
        .stack_bcd    (stackBcd),
        .pot_bcd      (potBcd),
        .total_bcd    (totalBcd),
        .busy         (busy),
        .done         (done),
        .digits_valid (digitsValid)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Port digit [0] is the most significant; rebuild a readable MS-first hex word.
    function automatic logic [15:0] msFirst(input logic [3:0][3:0] v);
        return {v[0], v[1], v[2], v[3]};
    endfunction

    function automatic logic [15:0] fmt(input logic [15:0] v);
`ifdef MONEY_BCD_BLANK_EN
        logic [15:0] r;
        r = v;
        for (int i = 3; i >= 1; i--) begin
            if (r[4*i +: 4] == 4'd0) r[4*i +: 4] = 4'hF;
            else break;
        end
        return r;
`else
        return v;
`endif
    endfunction

    function automatic logic [79:0] outWord();
        return {msFirst(stackBcd[0]), msFirst(stackBcd[1]), msFirst(potBcd[0]), msFirst(potBcd[1]), msFirst(totalBcd)};
    endfunction

    task automatic checkOutput(input string name, input logic [79:0] got, input logic [79:0] exp);
        totalCnt++;
        if (got !== exp) begin
            badCnt++;
            $display("[TB] FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: pops one expected set per done pulse; between pulses the outputs must hold.
    always @(negedge clk) begin
        if (!reset) begin
            if (done) begin
                if (sbq.size() == 0) begin
                    checkOutput("unexpected_done", 80'd1, 80'd0);
                end else begin
                    cur = sbq.pop_front();
                    checkOutput("done_cycle", 80'(cyc), 80'(cur.doneCyc));
                    checkOutput("stack0", 80'(msFirst(stackBcd[0])), 80'(cur.s0));
                    checkOutput("stack1", 80'(msFirst(stackBcd[1])), 80'(cur.s1));
                    checkOutput("pot0", 80'(msFirst(potBcd[0])), 80'(cur.p0));
                    checkOutput("pot1", 80'(msFirst(potBcd[1])), 80'(cur.p1));
                    checkOutput("total", 80'(msFirst(totalBcd)), 80'(cur.t));
                    checkOutput("valid_at_done", 80'(digitsValid), 80'd1);
                    checkOutput("busy_at_done", 80'(busy), 80'd0);
                    held     = {cur.s0, cur.s1, cur.p0, cur.p1, cur.t};
                    expValid = 1'b1;
                end
            end else begin
                checkOutput("hold", outWord(), held);
                checkOutput("valid_hold", 80'(digitsValid), 80'(expValid));
                checkOutput("busy", 80'(busy),
                            80'((sbq.size() > 0) && (cyc >= sbq[0].doneCyc - 65) && (cyc < sbq[0].doneCyc)));
            end
        end
    end

    task automatic applyStimulus(input int s0, input int s1, input int p0, input int p1, input int t,
                                 input logic [15:0] e0, input logic [15:0] e1, input logic [15:0] e2,
                                 input logic [15:0] e3, input logic [15:0] e4);
        expT e;
        playerStacks[0] = 11'(s0);
        playerStacks[1] = 11'(s1);
        playerPots[0]   = 11'(p0);
        playerPots[1]   = 11'(p1);
        potSize         = 11'(t);
        frameStart      = 1'b1;
        e.s0 = fmt(e0); e.s1 = fmt(e1); e.p0 = fmt(e2); e.p1 = fmt(e3); e.t = fmt(e4);
        e.doneCyc = cyc + 66;
        sbq.push_back(e);
        @(posedge clk); #1;
        frameStart      = 1'b0;
        playerStacks[0] = 11'($urandom_range(0, 2047));
        playerStacks[1] = 11'($urandom_range(0, 2047));
        playerPots[0]   = 11'($urandom_range(0, 2047));
        playerPots[1]   = 11'($urandom_range(0, 2047));
        potSize         = 11'($urandom_range(0, 2047));
    endtask

    task automatic waitIdle(input int budget);
        int n;
        n = 0;
        while (sbq.size() != 0 && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (sbq.size() != 0) begin
            checkOutput("done_timeout", 80'd1, 80'd0);
            sbq.delete();
        end
    endtask

    task automatic waitDone(input int budget);
        int n;
        n = 0;
        while (!done && n < budget) begin
            @(posedge clk); #1;
            n++;
        end
        if (!done) checkOutput("wait_done_timeout", 80'd1, 80'd0);
    endtask

    initial begin
        cyc          = 0;
        totalCnt     = 0;
        badCnt       = 0;
        held         = '0;
        expValid     = 1'b0;
        reset        = 1'b1;
        frameStart   = 1'b0;
        playerStacks = '0;
        playerPots   = '0;
        potSize      = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        checkOutput("rst_outputs", outWord(), 80'd0);
        checkOutput("rst_busy", 80'(busy), 80'd0);
        checkOutput("rst_done", 80'(done), 80'd0);
        checkOutput("rst_valid", 80'(digitsValid), 80'd0);

        // T1: main conversion
        applyStimulus(1000, 500, 25, 0, 2047, 16'h1000, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitIdle(100);

        // T2: input change and extra frame_start while busy are both ignored
        applyStimulus(123, 500, 25, 0, 2047, 16'h0123, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        repeat (9) @(posedge clk);
        #1 playerStacks[0] = 11'd456;
        repeat (10) @(posedge clk);
        #1 frameStart = 1'b1;
        @(posedge clk);
        #1 frameStart = 1'b0;
        waitIdle(100);
        repeat (10) @(posedge clk);
        #1;
        applyStimulus(456, 500, 25, 0, 2047, 16'h0456, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitIdle(100);

        // T3: reset mid-conversion discards the frame and clears the outputs
        applyStimulus(1111, 222, 33, 4, 555, 16'h1111, 16'h0222, 16'h0033, 16'h0004, 16'h0555);
        repeat (29) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        sbq.delete();
        held     = '0;
        expValid = 1'b0;
        checkOutput("midrst_outputs", outWord(), 80'd0);
        checkOutput("midrst_busy", 80'(busy), 80'd0);
        checkOutput("midrst_valid", 80'(digitsValid), 80'd0);
        repeat (70) @(posedge clk);
        #1;

        // T4: boundary values
        applyStimulus(0, 9, 10, 999, 1999, 16'h0000, 16'h0009, 16'h0010, 16'h0999, 16'h1999);
        waitIdle(100);

        // T5: blanking candidates
        applyStimulus(7, 0, 1050, 2047, 1, 16'h0007, 16'h0000, 16'h1050, 16'h2047, 16'h0001);
        waitIdle(100);

        // T6: back-to-back frames, each started in the previous done cycle
        applyStimulus(1, 500, 25, 0, 2047, 16'h0001, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitDone(100);
        applyStimulus(22, 500, 25, 0, 2047, 16'h0022, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitDone(100);
        applyStimulus(333, 500, 25, 0, 2047, 16'h0333, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitDone(100);
        applyStimulus(1444, 500, 25, 0, 2047, 16'h1444, 16'h0500, 16'h0025, 16'h0000, 16'h2047);
        waitIdle(100);

        repeat (5) @(posedge clk);
        #1;
        $display("test done: total=%0d bad=%0d", totalCnt, badCnt);
        $finish;
    end

endmodule
